npc_ctrl: RTL
=============

# npc_ctrl

Next-PC controller for the five-stage MIPS pipeline, the producer side of the PC register's `newpc` input. It takes the current fetch address and the redirect requests from later stages: branch and `jal`/`j` from D, `jr`/`jalr` from D, exception entry and `eret` from M. It arbitrates them and drives the next fetch address. A redirect that arrives while fetch is stalled is captured and replayed, so single-cycle redirect pulses are never lost.

## Interface
- No parameters. Constants: exception vector `32'h00004180`; sequential step `+4`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on a rising edge where it is high.
- `StallF`  in  1  fetch stall from the hazard unit; the PC register does not load while this is 1.
- `pc_f`  in  32  current fetch PC, from the PC register output.
- `br_req`  in  1  D-stage taken branch or `j`/`jal`.
- `br_target`  in  32  branch/jump target.
- `jr_req`  in  1  D-stage `jr`/`jalr`.
- `jr_target`  in  32  forwarded register value.
- `exc_req`  in  1  M-stage exception/interrupt entry; a pulse.
- `eret_req`  in  1  M-stage `eret`; a pulse.
- `epc`  in  32  CP0 EPC value.
- `newpc`  out  32  next fetch address, to the PC register.
- `redirect_pending`  out  1  a captured redirect is waiting.
- `addr_err`  out  1  selected `newpc[1:0] != 0`.

## Operation
- Priority classes, highest first:
  - 3 = `exc_req`, target `0x4180`
  - 2 = `eret_req`, target `epc`
  - 1 = `jr_req`, target `jr_target`
  - 0 = `br_req`, target `br_target`
  - none = sequential `pc_f + 4`
- State: `pend_valid`, `pend_cls[1:0]`, `pend_target[31:0]`. Two-state FSM:
  - IDLE: `pend_valid=0`.
  - PEND: `pend_valid=1`.
- Arbitration (combinational):
  - Take the highest-class live request.
  - Compare it with the pending entry, if any. A live request wins when its class is >= `pend_cls`; otherwise the pending entry wins.
  - `newpc` = winner's target, or `pc_f+4` if there is no request and no pending entry.
- IDLE → PEND: on an edge with `StallF=1` and any live request. The winner's class and target are captured.
- PEND → PEND: on an edge with `StallF=1`. The entry is replaced only if a live request has class >= `pend_cls`; otherwise it holds.
- PEND → IDLE, or IDLE stays: on any edge with `StallF=0`. The PC register consumes `newpc` that cycle.
- `redirect_pending` = `pend_valid`.
- `addr_err` = `|newpc[1:0]`, combinational. The target is passed unmodified; the exception logic downstream raises AdEL.
- Arithmetic: `pc_f+4` is modulo 2^32, so `0xFFFFFFFC` becomes `0x00000000`. There are no range checks.

## Timing
- `newpc`, `addr_err` and `redirect_pending` are combinational from the current inputs and state. There is zero added latency: a redirect presented in cycle N with `StallF=0` is loaded into the PC at edge N.
- A redirect presented with `StallF=1` reaches the PC on the first edge with `StallF=0`, even if the request input has since dropped.
- Reset: on an edge with `reset=1`, `pend_valid←0`, `pend_cls←0`, `pend_target←0`.
  - After reset, `redirect_pending=0` and `newpc=pc_f+4` until a request arrives.
  - Reset overrides a simultaneous stall or request; a pending redirect is discarded.
- Simultaneous live requests resolve by class in the same cycle; lower classes are dropped, not queued.

## Configuration
- `NPC_EXC_EN` defined: `exc_req` and `eret_req` participate as classes 3 and 2.
- `NPC_EXC_EN` undefined:
  - Both inputs are ignored and the ports stay present.
  - Only classes 0 and 1 exist, and `pend_cls` never exceeds 1.
  - `newpc` is never `0x4180` unless `br_target` or `jr_target` supplies it.

## Test plan
- Reset, then `pc_f=0x3000`, no requests → `newpc=0x3004`, `redirect_pending=0`. `pc_f=0xFFFFFFFC` → `newpc=0x00000000`.
- `br_req=1`, `br_target=0x3020`, `StallF=0` → `newpc=0x3020` the same cycle; `redirect_pending` stays 0.
- `StallF=1`, one-cycle `jr_req`, `jr_target=0x3100`, then 2 more stall cycles with no requests:
  - `redirect_pending=1` from the next cycle.
  - `newpc=0x3100` throughout.
  - On `StallF=0`, the PC loads `0x3100` and `redirect_pending` returns to 0.
- Pending `br` to `0x3040` while stalled, then an `exc_req` pulse during the stall → pending replaced, and after release `newpc=0x4180`. Reversed order: a `br_req` during a pending exception → ignored, `0x4180` kept.
- Same cycle `exc_req`, `eret_req` (`epc=0x3200`), `br_req` with `StallF=0` → `newpc=0x4180`. With `NPC_EXC_EN` undefined → `newpc=br_target`.
- `jr_target=0x3002` → `addr_err=1`, `newpc=0x3002`. A pending redirect, then `reset=1` with `StallF=1` → `redirect_pending=0` the next cycle, `newpc=pc_f+4`.

Source files
------------

// File: rtl/npc_ctrl_if.sv
// Fetch-redirect bus between the pipeline (master) and the next-PC controller (slave).
// The master drives the fetch PC, stall and redirect requests; the slave returns the next fetch address.
interface npc_ctrl_if;
  logic        StallF;
  logic [31:0] pc_f;
  logic        br_req;
  logic [31:0] br_target;
  logic        jr_req;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] newpc;
  logic        redirect_pending;
  logic        addr_err;

  modport master (
    output StallF, pc_f, br_req, br_target, jr_req, jr_target, exc_req, eret_req, epc,
    input  newpc, redirect_pending, addr_err
  );

  modport slave (
    input  StallF, pc_f, br_req, br_target, jr_req, jr_target, exc_req, eret_req, epc,
    output newpc, redirect_pending, addr_err
  );
endinterface

// File: rtl/npc_ctrl.sv
// Next-PC controller: arbitrates redirect requests by class and replays any redirect seen during a fetch stall.
// Define NPC_EXC_EN to let exc_req/eret_req take part as classes 3 and 2.
module npc_ctrl (
  input  logic       clk,
  input  logic       reset,
  npc_ctrl_if.slave  bus
);
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [1:0]  CLS_BR     = 2'd0;
  localparam logic [1:0]  CLS_JR     = 2'd1;
`ifdef NPC_EXC_EN
  localparam logic [1:0]  CLS_ERET   = 2'd2;
  localparam logic [1:0]  CLS_EXC    = 2'd3;
`endif

  typedef enum logic {IDLE, PEND} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_pend_cls, w_pend_cls_nxt;
  logic [31:0] r_pend_target, w_pend_target_nxt;

  logic        w_live_valid;
  logic [1:0]  w_live_cls;
  logic [31:0] w_live_target;
  logic        w_live_wins;
  logic [31:0] w_newpc;

  // Later assignments override earlier ones, so the highest class is written last.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_live_valid  = bus.br_req | bus.jr_req;
    w_live_cls    = CLS_BR;
    w_live_target = bus.br_target;
    if (bus.jr_req) begin
      w_live_cls    = CLS_JR;
      w_live_target = bus.jr_target;
    end
`ifdef NPC_EXC_EN
    w_live_valid = w_live_valid | bus.exc_req | bus.eret_req;
    if (bus.eret_req) begin
      w_live_cls    = CLS_ERET;
      w_live_target = bus.epc;
    end
    if (bus.exc_req) begin
      w_live_cls    = CLS_EXC;
      w_live_target = EXC_VECTOR;
    end
`endif
  end

`ifndef NPC_EXC_EN
  logic w_unused_exc;
  assign w_unused_exc = ^{bus.exc_req, bus.eret_req, bus.epc};
`endif

  // A live request of equal or higher class displaces the captured one.
  assign w_live_wins = w_live_valid && ((r_state == IDLE) || (w_live_cls >= r_pend_cls));

  always_comb begin
    w_newpc = bus.pc_f + PC_STEP;
    if (w_live_wins)          w_newpc = w_live_target;
    else if (r_state == PEND) w_newpc = r_pend_target;
  end

  assign bus.newpc            = w_newpc;
  assign bus.addr_err         = |w_newpc[1:0];
  assign bus.redirect_pending = (r_state == PEND);

  always_comb begin
    w_state_nxt       = r_state;
    w_pend_cls_nxt    = r_pend_cls;
    w_pend_target_nxt = r_pend_target;
    if (!bus.StallF) begin
      w_state_nxt = IDLE;
    end else if (w_live_wins) begin
      w_state_nxt       = PEND;
      w_pend_cls_nxt    = w_live_cls;
      w_pend_target_nxt = w_live_target;
    end
  end

  // NOTE: reset is synchronous, sampled only at the clock edge; state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pend_cls    <= '0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_cls    <= w_pend_cls_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end
endmodule
